// File: rtl/carry_accum_pkg.sv
// Shared types for the carry/accumulate pipeline: operation modes, the stage-1 payload
// and the registered flag bundle.
package carry_accum_pkg;

    localparam int unsigned MaxWidth = 64;

    typedef enum logic [1:0] {
        MODE_ADD = 2'd0,
        MODE_SUB = 2'd1,
        MODE_ACC = 2'd2,
        MODE_CLR = 2'd3
    } mode_e;

    // Sum is stored at the widest legal width; the top only uses the low WIDTH bits.
    typedef struct packed {
        logic [MaxWidth-1:0] sum;
        logic                cout;
        logic                prop;
        logic                x_msb;
        logic                y_msb;
        mode_e               mode;
    } s1_payload_t;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
        logic ones;
        logic prop;
    } flags_t;

    function automatic logic calc_ovf(input logic x_msb, input logic y_msb,
                                      input logic sum_msb);
        return (x_msb == y_msb) && (sum_msb != x_msb);
    endfunction

endpackage

// File: rtl/carry_slice.sv
// WIDTH-bit generate/propagate ripple chain returning sum, carry-out and the
// all-bits-propagate indication.
module carry_slice #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    input  logic             c_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             prop_o
);

    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prp;
    logic [WIDTH:0]   carry;

    assign gen = x_i & y_i;
    assign prp = x_i ^ y_i;

    always_comb begin
        carry    = '0;
        carry[0] = c_i;
        for (int i = 0; i < WIDTH; i++) begin
            carry[i+1] = gen[i] | (prp[i] & carry[i]);
        end
    end

    assign sum_o  = prp ^ carry[WIDTH-1:0];
    assign cout_o = carry[WIDTH];
    assign prop_o = &prp;

endmodule

// File: rtl/carry_accum_pipe.sv
// Two-stage add/sub/accumulate/clear pipeline with valid/ready on both sides;
// the accumulator updates on the accept edge so back-to-back ACCs need no forwarding.
module carry_accum_pipe #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_ones,
    output logic             out_prop
);

    import carry_accum_pkg::*;

    mode_e            mode;
    logic [WIDTH-1:0] op_x;
    logic [WIDTH-1:0] op_y;
    logic             op_c;
    logic [WIDTH-1:0] sl_sum;
    logic             sl_cout;
    logic             sl_prop;

    logic [WIDTH-1:0] acc_q, acc_d;
    s1_payload_t      s1_q, s1_d;
    logic             s1_valid_q, s1_valid_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    flags_t           flags_q, flags_d;

    logic             s1_adv;
    logic             s2_adv;
    logic             accept;
    logic [WIDTH-1:0] s1_sum;

    assign mode   = mode_e'(in_mode);
    assign s2_adv = !s2_valid_q || out_ready;
    assign s1_adv = s1_valid_q && s2_adv;
    assign in_ready = !s1_valid_q || s2_adv;
    assign accept = in_valid && in_ready;

    always_comb begin
        op_x = '0;
        op_y = '0;
        op_c = 1'b0;
        unique case (mode)
            MODE_ADD: begin
                op_x = in_a;
                op_y = in_b;
                op_c = in_cin;
            end
            MODE_SUB: begin
                op_x = in_a;
                op_y = ~in_b;
                op_c = 1'b1;
            end
            MODE_ACC: begin
                op_x = acc_q;
                op_y = in_a;
            end
            default: ;
        endcase
    end

    carry_slice #(
        .WIDTH (WIDTH)
    ) u_slice (
        .x_i    (op_x),
        .y_i    (op_y),
        .c_i    (op_c),
        .sum_o  (sl_sum),
        .cout_o (sl_cout),
        .prop_o (sl_prop)
    );

    always_comb begin
        acc_d      = acc_q;
        s1_d       = s1_q;
        s1_valid_d = s1_adv ? 1'b0 : s1_valid_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_d       = '0;
            s1_d.mode  = mode;
            if (mode != MODE_CLR) begin
                s1_d.sum   = MaxWidth'(sl_sum);
                s1_d.cout  = sl_cout;
                s1_d.prop  = sl_prop;
                s1_d.x_msb = op_x[WIDTH-1];
                s1_d.y_msb = op_y[WIDTH-1];
            end
            if (mode == MODE_ACC) begin
                acc_d = sl_sum;
            end else if (mode == MODE_CLR) begin
                acc_d = '0;
            end
        end
    end

    assign s1_sum = s1_q.sum[WIDTH-1:0];

    if (WIDTH < MaxWidth) begin : g_sum_pad
        logic unused_sum_hi;
        assign unused_sum_hi = ^s1_q.sum[MaxWidth-1:WIDTH];
    end

    always_comb begin
        sum_d      = sum_q;
        flags_d    = flags_q;
        s2_valid_d = s2_adv ? 1'b0 : s2_valid_q;
        if (s1_adv) begin
            s2_valid_d = 1'b1;
            if (s1_q.mode == MODE_CLR) begin
                sum_d        = '0;
                flags_d      = '0;
                flags_d.zero = 1'b1;
            end else begin
                sum_d        = s1_sum;
                flags_d.cout = s1_q.cout;
                flags_d.ovf  = calc_ovf(s1_q.x_msb, s1_q.y_msb, s1_sum[WIDTH-1]);
                flags_d.zero = (s1_sum == '0);
                flags_d.ones = &s1_sum;
                flags_d.prop = s1_q.prop;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            s1_q       <= '0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            sum_q      <= '0;
            flags_q    <= '0;
        end else begin
            acc_q      <= acc_d;
            s1_q       <= s1_d;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            sum_q      <= sum_d;
            flags_q    <= flags_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_sum   = sum_q;
    assign out_cout  = flags_q.cout;
    assign out_ovf   = flags_q.ovf;
    assign out_zero  = flags_q.zero;
    assign out_ones  = flags_q.ones;
    assign out_prop  = flags_q.prop;

endmodule

// File: tb/tb_carry_accum_pipe.sv
// Scoreboard bench for carry_accum_pipe: directed cases with fixed expectations plus
// randomized traffic checked against an arithmetic reference model.
module tb_carry_accum_pipe;

    localparam int W = 4;
    localparam int M = 1 << W;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_mode;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         out_zero;
    logic         out_ones;
    logic         out_prop;

    int checks = 0;
    int errors = 0;
    int acc_m  = 0;
    bit rand_rdy = 0;
    logic [W+4:0] sb[$];

    carry_accum_pipe #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero),
        .out_ones  (out_ones),
        .out_prop  (out_prop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W+4:0] pack(input int s, input bit c, input bit v, input bit z,
                                          input bit o, input bit p);
        logic [W-1:0] sv;
        sv = W'(s);
        return {sv, c, v, z, o, p};
    endfunction

    function automatic int sgn(input int v);
        return (v >= M / 2) ? v - M : v;
    endfunction

    function automatic bit out_of_range(input int v);
        return (v > M / 2 - 1) || (v < -(M / 2));
    endfunction

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic logic [W+4:0] model(input int mode, input int a, input int b,
                                           input int cin, input int acc, output int acc_n);
        int full;
        int s;
        bit c;
        bit v;
        bit p;
        acc_n = acc;
        full  = 0;
        c     = 0;
        v     = 0;
        p     = 0;
        case (mode)
            0: begin
                full = a + b + cin;
                c    = full >= M;
                v    = out_of_range(sgn(a) + sgn(b) + cin);
                p    = ((a ^ b) == M - 1);
            end
            1: begin
                full = a - b + M;
                c    = a >= b;
                v    = out_of_range(sgn(a) - sgn(b));
                p    = (a == b);
            end
            2: begin
                full  = acc + a;
                c     = full >= M;
                v     = out_of_range(sgn(acc) + sgn(a));
                p     = ((acc ^ a) == M - 1);
                acc_n = full % M;
            end
            default: begin
                full  = 0;
                acc_n = 0;
            end
        endcase
        s = full % M;
        return pack(s, c, v, s == 0, s == M - 1, p);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per output handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: got %0h with empty scoreboard",
                         {out_sum, out_cout, out_ovf, out_zero, out_ones, out_prop});
            end else begin
                logic [W+4:0] exp;
                logic [W+4:0] act;
                exp = sb.pop_front();
                act = {out_sum, out_cout, out_ovf, out_zero, out_ones, out_prop};
                if (act !== exp) begin
                    errors++;
                    $display("FAIL result {sum,cout,ovf,zero,ones,prop}: got %b expected %b",
                             act, exp);
                end
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Offers one op until accepted; pushes the fixed expectation or the model's.
    task automatic send(input int m, input int a, input int b, input int cin,
                        input bit use_exp, input logic [W+4:0] exp);
        bit acc_ok;
        int acc_n;
        logic [W+4:0] r;
        acc_ok   = 0;
        in_valid = 1'b1;
        in_mode  = 2'(m);
        in_a     = W'(a);
        in_b     = W'(b);
        in_cin   = 1'(cin);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                r     = model(m, a, b, cin, acc_m, acc_n);
                acc_m = acc_n;
                sb.push_back(use_exp ? exp : r);
                acc_ok = 1;
            end
            @(posedge clk);
            #1;
            if (acc_ok) break;
        end
        in_valid = 1'b0;
        if (!acc_ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready 0 for 200 cycles expected 1");
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain_pending", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_mode   = 2'd0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("reset_outputs",
            64'({out_valid, in_ready, out_sum, out_cout, out_ovf, out_zero, out_ones, out_prop}),
            64'({1'b0, 1'b1, {(W + 5){1'b0}}}));
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(3, 0, 0, 0, 1, pack(0, 0, 0, 1, 0, 0));
        send(2, 0, 0, 0, 1, pack(0, 0, 0, 1, 0, 0));
        send(0, 15, 1, 0, 1, pack(0, 1, 0, 1, 0, 0));
        send(0, 5, 10, 0, 1, pack(15, 0, 0, 0, 1, 1));
        send(1, 3, 5, 0, 1, pack(14, 0, 0, 0, 0, 0));
        send(1, 8, 1, 0, 1, pack(7, 1, 1, 0, 0, 0));
        send(1, 6, 6, 0, 1, pack(0, 1, 0, 1, 0, 1));
        send(2, 7, 0, 0, 1, pack(7, 0, 0, 0, 0, 0));
        send(2, 7, 0, 0, 1, pack(14, 0, 1, 0, 0, 0));
        send(2, 7, 0, 0, 1, pack(5, 1, 0, 0, 0, 0));
        send(3, 0, 0, 0, 1, pack(0, 0, 0, 1, 0, 0));
        send(2, 0, 0, 0, 1, pack(0, 0, 0, 1, 0, 0));
        drain();

        // Backpressure: two ops fill the pipe, the third must wait.
        out_ready = 1'b0;
        send(0, 1, 1, 0, 1, pack(2, 0, 0, 0, 0, 0));
        send(0, 2, 2, 0, 1, pack(4, 0, 0, 0, 0, 0));
        in_valid = 1'b1;
        in_mode  = 2'd0;
        in_a     = W'(3);
        in_b     = W'(3);
        in_cin   = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("full_in_ready", 64'(in_ready), 64'd0);
            chk("stall_out_hold", 64'({out_valid, out_sum}), 64'({1'b1, 4'd2}));
        end
        fork
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join_none
        @(posedge clk);
        #1;
        send(0, 3, 3, 0, 1, pack(6, 0, 0, 0, 0, 0));
        drain();

        // Randomized traffic with random backpressure against the reference model.
        rand_rdy = 1;
        for (int n = 0; n < 1000; n++) begin
            int m;
            m = ($urandom_range(0, 15) == 0) ? 3 : int'($urandom_range(0, 2));
            send(m, int'($urandom_range(0, M - 1)), int'($urandom_range(0, M - 1)),
                 int'($urandom_range(0, 1)), 0, '0);
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rand_rdy  = 0;
        out_ready = 1'b1;
        drain();

        // Asynchronous reset with ops in flight and a non-zero accumulator.
        send(3, 0, 0, 0, 1, pack(0, 0, 0, 1, 0, 0));
        send(2, 9, 0, 0, 1, pack(9, 0, 0, 0, 0, 0));
        drain();
        out_ready = 1'b0;
        send(0, 1, 1, 0, 0, '0);
        send(0, 2, 2, 0, 0, '0);
        chk("pre_reset_out_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_state", 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));
        sb.delete();
        acc_m = 0;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(2, 1, 0, 0, 1, pack(1, 0, 0, 0, 0, 0));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish before 2000000");
        $fatal(1);
    end

endmodule
